lcd_char_writer: RTL and testbench
==================================

# lcd_char_writer

Responder for the processor's `LCD` instruction: accepts one byte (character or command) from the execute stage and drives the HD44780-compatible character LCD over its 4-bit interface. It also performs the display's power-on initialization. It sits between the CPU datapath and the board LCD pins. The CPU stalls on `oReady` low until the display has absorbed the byte.

## Interface
Parameters:
- `POWERUP_CYCLES`, 750000: wait after reset before the first init nibble (15 ms at 50 MHz).
- `INIT_LONG_CYCLES`, 205000: wait after the first init nibble (4.1 ms).
- `INIT_SHORT_CYCLES`, 5000: wait after the second init nibble (100 µs).
- `NIBBLE_GAP_CYCLES`, 50: gap between the high and low nibble of a byte (1 µs).
- `BYTE_WAIT_CYCLES`, 2000: wait after a byte or after init nibbles 3 and 4 (40 µs).
- `CLEAR_WAIT_CYCLES`, 82000: wait after the clear/home commands (1.64 ms).
- `E_PULSE_CYCLES`, 12: high time of `oLCD_E` (240 ns).

Ports:
- `Clock`  in  1  system clock, 50 MHz.
- `Reset`  in  1  asynchronous, active-low reset.
- `iWrite`  in  1  single-cycle request from the `LCD` instruction.
- `iCommand`  in  1  1 = instruction register (RS=0), 0 = data register (RS=1).
- `iData`  in  8  byte to send, taken from the instruction's source register.
- `oReady`  out  1  high when `iWrite` will be accepted.
- `oLCD_E`  out  1  LCD enable strobe.
- `oLCD_RS`  out  1  LCD register select.
- `oLCD_RW`  out  1  read/write select; tied low, write-only.
- `oLCD_Data`  out  4  LCD data bus D[7:4].

## Operation
- Reset values: `oReady`=0, `oLCD_E`=0, `oLCD_RS`=0, `oLCD_RW`=0, `oLCD_Data`=4'h0, FSM=`PWR_WAIT`, delay counter=0.
- States: `PWR_WAIT` → `INIT_NIB` (4 nibbles: 3,3,3,2; RS=0) → `CFG` (bytes 0x28, 0x06, 0x0C, 0x01; RS=0) → `IDLE` → `SEND_HI` → `GAP` → `SEND_LO` → `POST_WAIT` → `IDLE`.
- Init waits after each init nibble:
  - Nibble 1: `INIT_LONG_CYCLES`.
  - Nibble 2: `INIT_SHORT_CYCLES`.
  - Nibbles 3 and 4: `BYTE_WAIT_CYCLES`.
- Config bytes go through the same `SEND_HI`/`GAP`/`SEND_LO`/`POST_WAIT` path as user bytes.
- `oReady`=1 only in `IDLE`.
- Handshake: `iWrite`=1 while `oReady`=1 latches `iData` and `iCommand`. `oReady` falls on the next edge, and the FSM moves to `SEND_HI`.
  - `iWrite` while `oReady`=0 is ignored, with no queueing. The CPU must hold the instruction until ready.
- RS = ~latched `iCommand`. Bus = `iData[7:4]`, then `iData[3:0]`.
- Post-byte wait: `CLEAR_WAIT_CYCLES` if the byte is a command and `iData` ≤ 8'h03 (clear/home); otherwise `BYTE_WAIT_CYCLES`.
- The delay counter is 20 bits, loads N-1 and counts down to 0. A state exit occurs on the cycle the counter reads 0, so each wait lasts exactly N cycles.
- Reset asserted mid-byte: all outputs return to their reset values immediately, and the full init sequence reruns on release.

## Timing
- Nibble strobe, relative to entering `SEND_HI`/`SEND_LO`/`INIT_NIB`:
  - RS and data valid from cycle 0.
  - `oLCD_E` high for cycles 2..(1+`E_PULSE_CYCLES`).
  - RS and data held through cycle 3+`E_PULSE_CYCLES`. That gives 2 cycles of setup (40 ns) and 2 cycles of hold (40 ns), which are the minimums.
- Strobe length: `E_PULSE_CYCLES`+4 = 16 cycles per nibble.
- User byte, accept edge to `oReady` high again: 1 + 16 + `NIBBLE_GAP_CYCLES` + 16 + `BYTE_WAIT_CYCLES` = 2083 cycles at defaults.
- The first `IDLE` is reached after power-up, four init nibbles with their waits, and four config bytes.
- `oLCD_Data` is driven 4'h0 whenever no nibble is being presented.

## Configuration
- Macro: `LCD_INIT_EN`.
- Defined: behaviour as above.
- Undefined: `PWR_WAIT`, `INIT_NIB` and `CFG` are not built. The FSM resets to `IDLE`, and `oReady` rises on the first clock edge after reset release. Firmware must issue the init and config sequence as `LCD` commands, which keeps simulations short.

## Structure
- Shared `Defintions.v` holds:
  - FSM state encodings (`LCD_ST_*`).
  - Config byte constants `LCD_FUNC_SET`=8'h28, `LCD_ENTRY`=8'h06, `LCD_DISP_ON`=8'h0C, `LCD_CLEAR`=8'h01.
- Sub-module `lcd_nibble_strobe` is instantiated once. Inputs: start, nibble, rs. Outputs: the pins and done. It owns the E pulse and the setup/hold counter, and its done signal is a 1-cycle pulse.
- The top level owns the FSM, the delay counter and the handshake.

## Test plan
Unless noted, tests run with `LCD_INIT_EN` defined and reduced timing parameters: `POWERUP`=20, `INIT_LONG`=10, `INIT_SHORT`=5, `GAP`=3, `BYTE_WAIT`=8, `CLEAR_WAIT`=30, `E_PULSE`=4.
- Reset release → E strobes carry nibbles 3,3,3,2, then 2,8,0,6,0,C,0,1, all with RS=0. `oReady` rises only after the 30-cycle clear wait.
- In `IDLE`, `iWrite` with `iCommand`=0 and `iData`=8'h48 ('H') → `oReady` falls next edge. Strobes carry 4'h4 then 4'h8 with RS=1. `oReady` returns after 1+8+3+8+8 = 28 cycles.
- `iWrite` with `iCommand`=1 and `iData`=8'h01 → RS=0, post-byte wait is 30 cycles. `iData`=8'h80 → wait is 8 cycles.
- `iWrite` pulsed while `oReady`=0 with `iData`=8'h55 → no extra strobes. The in-flight byte is unchanged.
- `Reset` asserted during `SEND_LO` → E, RS and data go to 0 with no clock edge needed. After release, the init sequence restarts from `PWR_WAIT`.
- `LCD_INIT_EN` undefined → `oReady`=1 one edge after reset release, and no strobes occur before the first `iWrite`.

Source files
------------

// File: rtl/lcd_char_writer_pkg.sv
// Shared definitions for the LCD character writer: FSM encodings, wait selectors, config bytes.
// The power-on init/config path is only built when LCD_INIT_EN is defined.
package lcd_char_writer_pkg;

    localparam int DELAY_W = 20;

    typedef enum logic [3:0] {
        LCD_ST_PWR_WAIT,
        LCD_ST_INIT_NIB,
        LCD_ST_INIT_WAIT,
        LCD_ST_CFG,
        LCD_ST_IDLE,
        LCD_ST_SEND_HI,
        LCD_ST_GAP,
        LCD_ST_SEND_LO,
        LCD_ST_POST_WAIT
    } lcd_state_e;

    typedef enum logic [2:0] {
        W_PWR,
        W_LONG,
        W_SHORT,
        W_GAP,
        W_BYTE,
        W_CLEAR
    } wait_sel_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_byte = LCD_FUNC_SET;
            2'd1:    cfg_byte = LCD_ENTRY;
            2'd2:    cfg_byte = LCD_DISP_ON;
            default: cfg_byte = LCD_CLEAR;
        endcase
    endfunction

    function automatic logic is_strobe_state(input lcd_state_e s);
        is_strobe_state = (s == LCD_ST_INIT_NIB) || (s == LCD_ST_SEND_HI) || (s == LCD_ST_SEND_LO);
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Presents one nibble on the LCD bus with 2 cycles setup, an E pulse, and 2 cycles hold.
// Cycle 0 is the cycle start is high; done pulses on the final hold cycle.
module lcd_nibble_strobe #(
    parameter int E_PULSE_CYCLES = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_data,
    output logic       done
);

    localparam int CW = $clog2(E_PULSE_CYCLES + 4);
    localparam logic [CW-1:0] E_ON  = CW'(2);
    localparam logic [CW-1:0] E_OFF = CW'(E_PULSE_CYCLES + 1);
    localparam logic [CW-1:0] LAST  = CW'(E_PULSE_CYCLES + 3);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    nib_q, nib_d;
    logic          rs_q, rs_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            nib_q  <= 4'h0;
            rs_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            nib_q  <= nib_d;
            rs_q   <= rs_d;
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        nib_d  = nib_q;
        rs_d   = rs_q;
        if (busy_q) begin
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(1);
            nib_d  = nibble;
            rs_d   = rs;
        end
    end

    // Cycle 0 drives straight from the inputs so the bus is valid on entry.
    assign lcd_data = busy_q ? nib_q : (start ? nibble : 4'h0);
    assign lcd_rs   = busy_q ? rs_q : (start & rs);
    assign lcd_e    = busy_q && (cnt_q >= E_ON) && (cnt_q <= E_OFF);
    assign done     = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit write-only driver for the CPU LCD instruction: handshake, byte FSM, waits.
// Define LCD_INIT_EN to build the power-on init nibbles and config bytes.
module lcd_char_writer
    import lcd_char_writer_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int INIT_LONG_CYCLES  = 205000,
    parameter int INIT_SHORT_CYCLES = 5000,
    parameter int NIBBLE_GAP_CYCLES = 50,
    parameter int BYTE_WAIT_CYCLES  = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int E_PULSE_CYCLES    = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic       iCommand,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

`ifdef LCD_INIT_EN
    localparam lcd_state_e RESET_ST = LCD_ST_PWR_WAIT;
`else
    localparam lcd_state_e RESET_ST = LCD_ST_IDLE;
`endif

    function automatic logic [DELAY_W-1:0] wait_load(input wait_sel_e sel);
        case (sel)
            W_PWR:   wait_load = DELAY_W'(POWERUP_CYCLES - 1);
            W_LONG:  wait_load = DELAY_W'(INIT_LONG_CYCLES - 1);
            W_SHORT: wait_load = DELAY_W'(INIT_SHORT_CYCLES - 1);
            W_GAP:   wait_load = DELAY_W'(NIBBLE_GAP_CYCLES - 1);
            W_CLEAR: wait_load = DELAY_W'(CLEAR_WAIT_CYCLES - 1);
            default: wait_load = DELAY_W'(BYTE_WAIT_CYCLES - 1);
        endcase
    endfunction

    lcd_state_e         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [7:0]         byte_q, byte_d;
    logic               cmd_q, cmd_d;
    logic               ready_q, ready_d;
    logic               active_q, active_d;
    logic               do_load;
    wait_sel_e          wait_sel;
    logic               accept;
    logic               strb_start, strb_done, strb_rs;
    logic [3:0]         strb_nib;
`ifdef LCD_INIT_EN
    logic [1:0]         init_idx_q, init_idx_d;
    logic [1:0]         cfg_idx_q, cfg_idx_d;
    logic               cfg_done_q, cfg_done_d;
    logic               pwr_armed_q, pwr_armed_d;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= RESET_ST;
            cnt_q       <= '0;
            byte_q      <= 8'h00;
            cmd_q       <= 1'b1;
            ready_q     <= 1'b0;
            active_q    <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx_q  <= 2'd0;
            cfg_idx_q   <= 2'd0;
            cfg_done_q  <= 1'b0;
            pwr_armed_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            cmd_q       <= cmd_d;
            ready_q     <= ready_d;
            active_q    <= active_d;
`ifdef LCD_INIT_EN
            init_idx_q  <= init_idx_d;
            cfg_idx_q   <= cfg_idx_d;
            cfg_done_q  <= cfg_done_d;
            pwr_armed_q <= pwr_armed_d;
`endif
        end
    end

    assign accept = iWrite && ready_q && (state_q == LCD_ST_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - DELAY_W'(1) : cnt_q;
        byte_d   = byte_q;
        cmd_d    = cmd_q;
        do_load  = 1'b0;
        wait_sel = W_BYTE;
`ifdef LCD_INIT_EN
        init_idx_d  = init_idx_q;
        cfg_idx_d   = cfg_idx_q;
        cfg_done_d  = cfg_done_q;
        pwr_armed_d = pwr_armed_q;
`endif
        case (state_q)
`ifdef LCD_INIT_EN
            LCD_ST_PWR_WAIT: begin
                // The arming cycle is the first of the N power-up cycles.
                if (!pwr_armed_q) begin
                    pwr_armed_d = 1'b1;
                    cnt_d       = wait_load(W_PWR) - DELAY_W'(1);
                end else if (cnt_q == '0) begin
                    state_d = LCD_ST_INIT_NIB;
                end
            end
            LCD_ST_INIT_NIB: begin
                if (strb_done) begin
                    state_d  = LCD_ST_INIT_WAIT;
                    do_load  = 1'b1;
                    wait_sel = (init_idx_q == 2'd0) ? W_LONG :
                               (init_idx_q == 2'd1) ? W_SHORT : W_BYTE;
                end
            end
            LCD_ST_INIT_WAIT: begin
                if (cnt_q == '0) begin
                    init_idx_d = init_idx_q + 2'd1;
                    state_d    = (init_idx_q == 2'd3) ? LCD_ST_CFG : LCD_ST_INIT_NIB;
                end
            end
            LCD_ST_CFG: begin
                byte_d  = cfg_byte(cfg_idx_q);
                cmd_d   = 1'b1;
                state_d = LCD_ST_SEND_HI;
            end
`endif
            LCD_ST_IDLE: begin
                if (accept) begin
                    byte_d  = iData;
                    cmd_d   = iCommand;
                    state_d = LCD_ST_SEND_HI;
                end
            end
            LCD_ST_SEND_HI: begin
                if (strb_done) begin
                    state_d  = LCD_ST_GAP;
                    do_load  = 1'b1;
                    wait_sel = W_GAP;
                end
            end
            LCD_ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = LCD_ST_SEND_LO;
                end
            end
            LCD_ST_SEND_LO: begin
                if (strb_done) begin
                    state_d  = LCD_ST_POST_WAIT;
                    do_load  = 1'b1;
                    wait_sel = (cmd_q && (byte_q <= 8'h03)) ? W_CLEAR : W_BYTE;
                end
            end
            LCD_ST_POST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = LCD_ST_IDLE;
`ifdef LCD_INIT_EN
                    if (!cfg_done_q) begin
                        if (cfg_idx_q == 2'd3) begin
                            cfg_done_d = 1'b1;
                        end else begin
                            cfg_idx_d = cfg_idx_q + 2'd1;
                            state_d   = LCD_ST_CFG;
                        end
                    end
`endif
                end
            end
            default: state_d = RESET_ST;
        endcase
        if (do_load) begin
            cnt_d = wait_load(wait_sel);
        end
    end

    // Ready lags IDLE entry by one edge, so a byte costs 1 cycle beyond its strobes and waits.
    assign ready_d  = (state_q == LCD_ST_IDLE) && !accept;
    assign active_d = is_strobe_state(state_q) && (state_d == state_q);

    assign strb_start = is_strobe_state(state_q) && !active_q;

    always_comb begin
        strb_nib = 4'h0;
        strb_rs  = ~cmd_q;
        case (state_q)
            LCD_ST_SEND_HI: strb_nib = byte_q[7:4];
            LCD_ST_SEND_LO: strb_nib = byte_q[3:0];
`ifdef LCD_INIT_EN
            LCD_ST_INIT_NIB: begin
                strb_nib = (init_idx_q == 2'd3) ? 4'h2 : 4'h3;
                strb_rs  = 1'b0;
            end
`endif
            default: strb_nib = 4'h0;
        endcase
    end

    lcd_nibble_strobe #(
        .E_PULSE_CYCLES(E_PULSE_CYCLES)
    ) u_strobe (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (strb_start),
        .nibble  (strb_nib),
        .rs      (strb_rs),
        .lcd_e   (oLCD_E),
        .lcd_rs  (oLCD_RS),
        .lcd_data(oLCD_Data),
        .done    (strb_done)
    );

    assign oReady  = ready_q;
    assign oLCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with reduced timing; follows LCD_INIT_EN if defined.
module tb_lcd_char_writer;

    localparam int P_POWERUP = 20;
    localparam int P_LONG    = 10;
    localparam int P_SHORT   = 5;
    localparam int P_GAP     = 3;
    localparam int P_BYTE    = 8;
    localparam int P_CLEAR   = 30;
    localparam int P_E       = 4;
    localparam int STRB      = P_E + 4;
    localparam int LAT_BYTE  = 1 + STRB + P_GAP + STRB + P_BYTE;
    localparam int LAT_CLEAR = 1 + STRB + P_GAP + STRB + P_CLEAR;

    typedef struct {
        logic       cmd;
        logic [7:0] data;
        logic       exp_rs;
        logic [3:0] exp_hi;
        logic [3:0] exp_lo;
        int         exp_lat;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iWrite = 1'b0;
    logic       iCommand = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oReady, oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_Data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int rdy_rise = 0;
    logic e_prev = 1'b0;
    logic rdy_prev = 1'b0;
    logic [4:0] strobes[$];
    vec_t vecs[7];

    always #5 Clock = ~Clock;

    lcd_char_writer #(
        .POWERUP_CYCLES   (P_POWERUP),
        .INIT_LONG_CYCLES (P_LONG),
        .INIT_SHORT_CYCLES(P_SHORT),
        .NIBBLE_GAP_CYCLES(P_GAP),
        .BYTE_WAIT_CYCLES (P_BYTE),
        .CLEAR_WAIT_CYCLES(P_CLEAR),
        .E_PULSE_CYCLES   (P_E)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iWrite   (iWrite),
        .iCommand (iCommand),
        .iData    (iData),
        .oReady   (oReady),
        .oLCD_E   (oLCD_E),
        .oLCD_RS  (oLCD_RS),
        .oLCD_RW  (oLCD_RW),
        .oLCD_Data(oLCD_Data)
    );

    // Bus monitor: records {rs, nibble} at each E rise, plus E-fall and ready-rise cycles.
    always @(posedge Clock) begin
        #2;
        cyc = cyc + 1;
        if (oLCD_E && !e_prev) strobes.push_back({oLCD_RS, oLCD_Data});
        if (!oLCD_E && e_prev) last_fall = cyc;
        if (oReady && !rdy_prev) rdy_rise = cyc;
        e_prev   = oLCD_E;
        rdy_prev = oReady;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (oReady) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [4:0] strobe_at(input int idx);
        if (idx < strobes.size()) return strobes[idx];
        return 5'h1F;
    endfunction

`ifdef LCD_INIT_EN
    task automatic check_init();
        logic [3:0] init_exp[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                     4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        bit ok;
        wait_ready(3000, ok);
        check("init_ready_reached", int'(ok), 1);
        check("init_strobe_count", strobes.size(), 12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("init_nibble_%0d", i), int'(strobe_at(i)), int'({1'b0, init_exp[i]}));
        end
        check("init_clear_wait", rdy_rise - last_fall, 2 + P_CLEAR + 1);
        $display("init sequence: %0d strobes, ready %0d cycles after last E", strobes.size(), rdy_rise - last_fall);
    endtask
`endif

    task automatic send(input logic cmd, input logic [7:0] d, input bit extra, output int lat);
        bit ok;
        wait_ready(200, ok);
        check("send_ready_before", int'(ok), 1);
        strobes.delete();
        iWrite   = 1'b1;
        iCommand = cmd;
        iData    = d;
        @(posedge Clock);
        #1;
        iWrite   = 1'b0;
        iCommand = ~cmd;
        iData    = 8'hFF;
        check("ready_fall_after_accept", int'(oReady), 0);
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge Clock);
            #1;
            lat++;
            if (extra && lat == 5) begin
                iWrite   = 1'b1;
                iCommand = 1'b0;
                iData    = 8'h55;
            end
            if (extra && lat == 12) iWrite = 1'b0;
            if (oReady) break;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        send(v.cmd, v.data, 1'b0, lat);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_strobe_count", idx), strobes.size(), 2);
        check($sformatf("v%0d_hi", idx), int'(strobe_at(0)), int'({v.exp_rs, v.exp_hi}));
        check($sformatf("v%0d_lo", idx), int'(strobe_at(1)), int'({v.exp_rs, v.exp_lo}));
        $display("vec %0d: cmd=%0d data=%02h latency=%0d strobes=%0d", idx, v.cmd, v.data, lat, strobes.size());
    endtask

    initial begin
        int lat;
        bit got;

        vecs[0] = '{cmd: 1'b0, data: 8'h48, exp_rs: 1'b1, exp_hi: 4'h4, exp_lo: 4'h8, exp_lat: LAT_BYTE};
        vecs[1] = '{cmd: 1'b1, data: 8'h01, exp_rs: 1'b0, exp_hi: 4'h0, exp_lo: 4'h1, exp_lat: LAT_CLEAR};
        vecs[2] = '{cmd: 1'b1, data: 8'h80, exp_rs: 1'b0, exp_hi: 4'h8, exp_lo: 4'h0, exp_lat: LAT_BYTE};
        vecs[3] = '{cmd: 1'b1, data: 8'h03, exp_rs: 1'b0, exp_hi: 4'h0, exp_lo: 4'h3, exp_lat: LAT_CLEAR};
        vecs[4] = '{cmd: 1'b1, data: 8'h04, exp_rs: 1'b0, exp_hi: 4'h0, exp_lo: 4'h4, exp_lat: LAT_BYTE};
        vecs[5] = '{cmd: 1'b0, data: 8'h01, exp_rs: 1'b1, exp_hi: 4'h0, exp_lo: 4'h1, exp_lat: LAT_BYTE};
        vecs[6] = '{cmd: 1'b0, data: 8'h3A, exp_rs: 1'b1, exp_hi: 4'h3, exp_lo: 4'hA, exp_lat: LAT_BYTE};

        repeat (3) @(negedge Clock);
        check("reset_ready", int'(oReady), 0);
        check("reset_e", int'(oLCD_E), 0);
        check("reset_rs", int'(oLCD_RS), 0);
        check("reset_rw", int'(oLCD_RW), 0);
        check("reset_data", int'(oLCD_Data), 0);
        strobes.delete();
        Reset = 1'b1;

`ifdef LCD_INIT_EN
        check_init();
`else
        @(posedge Clock);
        #1;
        check("ready_one_edge_after_release", int'(oReady), 1);
        repeat (50) @(negedge Clock);
        check("no_strobes_before_write", strobes.size(), 0);
        check("ready_held_idle", int'(oReady), 1);
        $display("no-init build: ready after first edge, %0d strobes while idle", strobes.size());
`endif

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // A write while busy must be dropped without disturbing the in-flight byte.
        send(1'b0, 8'h48, 1'b1, lat);
        check("busy_write_latency", lat, LAT_BYTE);
        check("busy_write_strobe_count", strobes.size(), 2);
        check("busy_write_hi", int'(strobe_at(0)), int'(5'h14));
        check("busy_write_lo", int'(strobe_at(1)), int'(5'h18));
        repeat (40) @(negedge Clock);
        check("busy_write_not_queued", strobes.size(), 2);
        $display("ignored write: latency=%0d strobes=%0d", lat, strobes.size());

        // Reset while the low nibble's E pulse is high.
        wait_ready(200, got);
        check("midreset_ready_before", int'(got), 1);
        strobes.delete();
        iWrite   = 1'b1;
        iCommand = 1'b0;
        iData    = 8'h48;
        @(negedge Clock);
        iWrite = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (strobes.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        check("midreset_reached_send_lo", int'(got), 1);
        check("midreset_e_high_before", int'(oLCD_E), 1);
        Reset = 1'b0;
        #1;
        check("midreset_e", int'(oLCD_E), 0);
        check("midreset_rs", int'(oLCD_RS), 0);
        check("midreset_data", int'(oLCD_Data), 0);
        check("midreset_ready", int'(oReady), 0);
        $display("mid-byte reset: E=%0d RS=%0d D=%0h ready=%0d", oLCD_E, oLCD_RS, oLCD_Data, oReady);
        repeat (2) @(negedge Clock);
        strobes.delete();
        Reset = 1'b1;
`ifdef LCD_INIT_EN
        check_init();
`else
        @(posedge Clock);
        #1;
        check("midreset_ready_after_release", int'(oReady), 1);
`endif
        run_vec(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
